// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO in front of a start/data/parity/stop serialiser with its own baud divider.
// Latency: push into an empty FIFO while idle drives the start bit one edge later; tx_ready drops while the FIFO is full.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIV_W-1:0]             baud_div,
  input  logic [1:0]                   data_bits,
  input  logic [1:0]                   parity_mode,
  input  logic                         two_stop,
  input  logic                         tx_en,
  input  logic                         flush,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         txd,
  output logic                         busy,
  output logic                         frame_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  state_t     state, state_n;
  logic [DIV_W-1:0] baud_cnt, cnt_n, div_q;
  logic [1:0] dbits_q, pmode_q;
  logic       two_q;
  logic [7:0] data_q, data_mask;
  logic [2:0] bit_idx, bit_n, bit_inc, last_bit;
  logic       stop_idx, stop_n;
  logic       txd_n;
  logic       bit_end, start_ok, par_en, par_bit;

  assign tx_ready = (fifo_count != FULL_CNT);
  // flush wins over a simultaneous push: the incoming word is dropped
  assign push     = tx_valid && tx_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign data_mask = 8'hFF >> (2'd3 - data_bits);
  assign bit_end   = (baud_cnt == '0);
  assign start_ok  = tx_en && (fifo_count != '0);
  assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_bit   = (^data_q) ^ (pmode_q == 2'b10);
  assign last_bit  = 3'd4 + {1'b0, dbits_q};
  assign bit_inc   = bit_idx + 3'd1;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      txd      <= 1'b1;
      div_q    <= '0;
      dbits_q  <= '0;
      pmode_q  <= '0;
      two_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      txd      <= txd_n;
      // frame configuration is frozen at pop time
      if (pop) begin
        div_q   <= baud_div;
        dbits_q <= data_bits;
        pmode_q <= parity_mode;
        two_q   <= two_stop;
        data_q  <= mem[rd_ptr] & data_mask;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = baud_cnt;
    bit_n      = bit_idx;
    stop_n     = stop_idx;
    txd_n      = txd;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          state_n = S_START;
          cnt_n   = baud_div;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          cnt_n   = div_q;
          bit_n   = 3'd0;
          txd_n   = data_q[0];
        end else begin
          cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = div_q;
          if (bit_idx == last_bit) begin
            if (par_en) begin
              state_n = S_PARITY;
              txd_n   = par_bit;
            end else begin
              state_n = S_STOP;
              stop_n  = 1'b0;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n = bit_inc;
            txd_n = data_q[bit_inc];
          end
        end else begin
          cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          stop_n  = 1'b0;
          cnt_n   = div_q;
          txd_n   = 1'b1;
        end else begin
          cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_q && !stop_idx) begin
            stop_n = 1'b1;
            cnt_n  = div_q;
          end else begin
            frame_done = 1'b1;
            // back-to-back: go straight to START without an idle cycle
            if (start_ok) begin
              pop     = 1'b1;
              state_n = S_START;
              cnt_n   = baud_div;
              txd_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
              txd_n   = 1'b1;
            end
          end
        end else begin
          cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule
